// File: rtl/vidtimgen.sv
// vidtimgen - programmable video timing generator.
//
// Divides clk into a character-clock step enable (ce) and runs horizontal and
// vertical position counters against a timing set taken from the input ports.
// The timing set is shadowed and only reloaded on the first step after reset
// and at every frame wrap, so mid-frame input changes never disturb a frame.
//
// Ports
//   clk, resb                     master clock, async active-low reset
//   h_total, v_total              last column / last line index
//   h_de_start/_end, v_de_*       display-enable windows [start, end)
//   h_sync_start/_end, v_sync_*   sync windows [start, end); start>end wraps
//   interlace                     alternate fields, half-line vsync offset
//   ce                            one-clk step enable
//   hsync_n, vsync_n, de, blank_n registered timing strobes
//   field, sof                    current field, start-of-frame pulse
//   hcnt, vcnt                    position counters
module vidtimgen #(
    parameter int HW     = 9,
    parameter int VW     = 10,
    parameter int CLKDIV = 4
) (
    input  logic          clk,
    input  logic          resb,
    input  logic [HW-1:0] h_total,
    input  logic [HW-1:0] h_de_start,
    input  logic [HW-1:0] h_de_end,
    input  logic [HW-1:0] h_sync_start,
    input  logic [HW-1:0] h_sync_end,
    input  logic [VW-1:0] v_total,
    input  logic [VW-1:0] v_de_start,
    input  logic [VW-1:0] v_de_end,
    input  logic [VW-1:0] v_sync_start,
    input  logic [VW-1:0] v_sync_end,
    input  logic          interlace,
    output logic          ce,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          de,
    output logic          blank_n,
    output logic          field,
    output logic          sof,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt
);

    localparam int            DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    // Window [s, e): empty when s==e, wraps through 0 when s>e.
    function automatic logic win_h(input logic [HW-1:0] c, s, e);
        if (s == e)     return 1'b0;
        else if (s < e) return (c >= s) && (c < e);
        else            return (c >= s) || (c < e);
    endfunction

    function automatic logic win_v(input logic [VW-1:0] c, s, e);
        if (s == e)     return 1'b0;
        else if (s < e) return (c >= s) && (c < e);
        else            return (c >= s) || (c < e);
    endfunction

    logic [DW-1:0] div_q, div_d;
    logic          ce_q, ce_d;
    logic          first_q, first_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic          de_q, de_d, blank_n_q, blank_n_d;
    logic          field_q, field_d, sof_q, sof_d;

    // Shadow timing set
    logic [HW-1:0] sh_h_total_q, sh_h_de_start_q, sh_h_de_end_q;
    logic [HW-1:0] sh_h_sync_start_q, sh_h_sync_end_q;
    logic [VW-1:0] sh_v_total_q, sh_v_de_start_q, sh_v_de_end_q;
    logic [VW-1:0] sh_v_sync_start_q, sh_v_sync_end_q;
    logic          sh_interlace_q;

    // Effective set for decoding the new position (new values on a load step)
    logic [HW-1:0] e_h_total, e_h_de_start, e_h_de_end, e_h_sync_start, e_h_sync_end;
    logic [VW-1:0] e_v_total, e_v_de_start, e_v_de_end, e_v_sync_start, e_v_sync_end;
    logic          e_interlace;

    logic          frame_wrap, load;
    logic [HW-1:0] ct_h, vs_off;
    logic [VW-1:0] ct_v, vs_line;
    logic          hs_act, vs_act, de_act;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        ce_d  = (div_d == DIV_LAST);

        // Wrap detection uses the shadow in force for the current frame.
        frame_wrap = (hcnt_q == sh_h_total_q) && (vcnt_q == sh_v_total_q);
        load       = ce_q && (first_q || frame_wrap);
        first_d    = first_q && !ce_q;

        e_h_total      = load ? h_total      : sh_h_total_q;
        e_h_de_start   = load ? h_de_start   : sh_h_de_start_q;
        e_h_de_end     = load ? h_de_end     : sh_h_de_end_q;
        e_h_sync_start = load ? h_sync_start : sh_h_sync_start_q;
        e_h_sync_end   = load ? h_sync_end   : sh_h_sync_end_q;
        e_v_total      = load ? v_total      : sh_v_total_q;
        e_v_de_start   = load ? v_de_start   : sh_v_de_start_q;
        e_v_de_end     = load ? v_de_end     : sh_v_de_end_q;
        e_v_sync_start = load ? v_sync_start : sh_v_sync_start_q;
        e_v_sync_end   = load ? v_sync_end   : sh_v_sync_end_q;
        e_interlace    = load ? interlace    : sh_interlace_q;

        // The very first step runs on the freshly loaded totals (the shadow
        // still holds zeros); later steps keep the current frame's totals.
        ct_h = first_q ? h_total : sh_h_total_q;
        ct_v = first_q ? v_total : sh_v_total_q;

        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        field_d   = field_q;
        hsync_n_d = hsync_n_q;
        vsync_n_d = vsync_n_q;
        de_d      = de_q;
        blank_n_d = blank_n_q;
        sof_d     = 1'b0;
        vs_off    = '0;
        vs_line   = '0;
        hs_act    = 1'b0;
        vs_act    = 1'b0;
        de_act    = 1'b0;

        if (ce_q) begin
            if (hcnt_q == ct_h) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == ct_v) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            if (frame_wrap && !first_q) begin
                field_d = e_interlace ? ~field_q : 1'b0;
                sof_d   = 1'b1;
            end

            // Vsync compares (line, column) against (line, offset): columns
            // before the offset still belong to the previous line.
            vs_off  = field_d ? (e_h_total >> 1) : '0;
            if (hcnt_d >= vs_off)  vs_line = vcnt_d;
            else if (vcnt_d == '0) vs_line = e_v_total;
            else                   vs_line = vcnt_d - 1'b1;

            hs_act = win_h(hcnt_d, e_h_sync_start, e_h_sync_end);
            vs_act = win_v(vs_line, e_v_sync_start, e_v_sync_end);
            de_act = win_h(hcnt_d, e_h_de_start, e_h_de_end) &&
                     win_v(vcnt_d, e_v_de_start, e_v_de_end);

            hsync_n_d = ~hs_act;
            vsync_n_d = ~vs_act;
            de_d      = de_act;
            blank_n_d = ~(hs_act || vs_act);
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            div_q     <= '0;
            ce_q      <= 1'b0;
            first_q   <= 1'b1;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            de_q      <= 1'b0;
            blank_n_q <= 1'b1;
            field_q   <= 1'b0;
            sof_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            ce_q      <= ce_d;
            first_q   <= first_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            de_q      <= de_d;
            blank_n_q <= blank_n_d;
            field_q   <= field_d;
            sof_q     <= sof_d;
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            sh_h_total_q      <= '0;
            sh_h_de_start_q   <= '0;
            sh_h_de_end_q     <= '0;
            sh_h_sync_start_q <= '0;
            sh_h_sync_end_q   <= '0;
            sh_v_total_q      <= '0;
            sh_v_de_start_q   <= '0;
            sh_v_de_end_q     <= '0;
            sh_v_sync_start_q <= '0;
            sh_v_sync_end_q   <= '0;
            sh_interlace_q    <= 1'b0;
        end else if (load) begin
            sh_h_total_q      <= h_total;
            sh_h_de_start_q   <= h_de_start;
            sh_h_de_end_q     <= h_de_end;
            sh_h_sync_start_q <= h_sync_start;
            sh_h_sync_end_q   <= h_sync_end;
            sh_v_total_q      <= v_total;
            sh_v_de_start_q   <= v_de_start;
            sh_v_de_end_q     <= v_de_end;
            sh_v_sync_start_q <= v_sync_start;
            sh_v_sync_end_q   <= v_sync_end;
            sh_interlace_q    <= interlace;
        end
    end

    assign ce      = ce_q;
    assign hsync_n = hsync_n_q;
    assign vsync_n = vsync_n_q;
    assign de      = de_q;
    assign blank_n = blank_n_q;
    assign field   = field_q;
    assign sof     = sof_q;
    assign hcnt    = hcnt_q;
    assign vcnt    = vcnt_q;

endmodule

// File: tb/tb_vidtimgen.sv
// Testbench for vidtimgen: a CLKDIV=1 instance carries the frame tests via a
// scoreboard; a CLKDIV=4 instance checks the divider.
module tb_vidtimgen;

    localparam int HW = 9;
    localparam int VW = 10;

    localparam int T_BASE   = 0;
    localparam int T_HWRAP  = 1;
    localparam int T_HEQ    = 2;
    localparam int T_INTL   = 3;
    localparam int T_SHADOW = 4;
    localparam int T_RESET  = 5;

    logic clk  = 1'b0;
    logic resb = 1'b0;
    logic [HW-1:0] h_total, h_de_start, h_de_end, h_sync_start, h_sync_end;
    logic [VW-1:0] v_total, v_de_start, v_de_end, v_sync_start, v_sync_end;
    logic          interlace;

    logic          ce1, hs1, vs1, de1, bl1, fl1, sof1;
    logic [HW-1:0] hc1;
    logic [VW-1:0] vc1;
    logic          ce4, hs4, vs4, de4, bl4, fl4, sof4;
    logic [HW-1:0] hc4;
    logic [VW-1:0] vc4;

    always #5 clk = ~clk;

    vidtimgen #(.HW(HW), .VW(VW), .CLKDIV(1)) dut1 (
        .clk(clk), .resb(resb),
        .h_total(h_total), .h_de_start(h_de_start), .h_de_end(h_de_end),
        .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
        .v_total(v_total), .v_de_start(v_de_start), .v_de_end(v_de_end),
        .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
        .interlace(interlace),
        .ce(ce1), .hsync_n(hs1), .vsync_n(vs1), .de(de1), .blank_n(bl1),
        .field(fl1), .sof(sof1), .hcnt(hc1), .vcnt(vc1)
    );

    vidtimgen #(.HW(HW), .VW(VW), .CLKDIV(4)) dut4 (
        .clk(clk), .resb(resb),
        .h_total(h_total), .h_de_start(h_de_start), .h_de_end(h_de_end),
        .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
        .v_total(v_total), .v_de_start(v_de_start), .v_de_end(v_de_end),
        .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
        .interlace(interlace),
        .ce(ce4), .hsync_n(hs4), .vsync_n(vs4), .de(de4), .blank_n(bl4),
        .field(fl4), .sof(sof4), .hcnt(hc4), .vcnt(vc4)
    );

    typedef struct {
        int          tid;
        int          idx;
        logic [24:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // {hcnt, vcnt, hsync_n, vsync_n, de, blank_n, sof, field}
    function automatic logic [24:0] pack(input int h, input int v, input bit hs_n,
                                         input bit vs_n, input bit d, input bit s,
                                         input bit f);
        return {9'(h), 10'(v), hs_n, vs_n, d, hs_n & vs_n, s, f};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected positions/strobes for steps 1..n after reset release,
    // written from the hand-derived rules of each test frame.
    task automatic push_run(input int tid, input int n);
        for (int i = 1; i <= n; i++) begin
            int   h, v, f;
            bit   hs, vs, d, s;
            exp_t e;
            if (tid == T_SHADOW && i >= 50) begin
                h = (i - 50) % 6;
                v = ((i - 50) / 6) % 5;
            end else begin
                h = i % 10;
                v = (i / 10) % 5;
            end
            f = (tid == T_INTL) ? (i / 50) % 2 : 0;
            d = (h >= 2 && h <= 7) && (v == 1 || v == 2);
            case (tid)
                T_HWRAP: hs = (h >= 8) || (h < 2);
                T_HEQ:   hs = 1'b0;
                default: hs = (h == 8);
            endcase
            if (f == 1) vs = (v == 4 && h >= 4) || (v == 0 && h < 4);
            else        vs = (v == 4);
            s = (h == 0 && v == 0);
            e.tid = tid;
            e.idx = i;
            e.val = pack(h, v, !hs, !vs, d, s, f[0]);
            sb_q.push_back(e);
        end
    endtask

    task automatic set_inputs(input int tid);
        h_total    = 9'd9;
        h_de_start = 9'd2;
        h_de_end   = 9'd8;
        v_total    = 10'd4;
        v_de_start = 10'd1;
        v_de_end   = 10'd3;
        v_sync_start = 10'd4;
        v_sync_end   = 10'd0;
        interlace  = (tid == T_INTL);
        case (tid)
            T_HWRAP: begin h_sync_start = 9'd8; h_sync_end = 9'd2; end
            T_HEQ:   begin h_sync_start = 9'd5; h_sync_end = 9'd5; end
            default: begin h_sync_start = 9'd8; h_sync_end = 9'd9; end
        endcase
    endtask

    // Reset, program, release just after a negedge, queue expectations.
    task automatic start_test(input int tid, input int n);
        @(negedge clk);
        #1 resb = 1'b0;
        set_inputs(tid);
        repeat (3) @(negedge clk);
        #1 resb = 1'b1;
        push_run(tid, n);
    endtask

    task automatic drain(input int tid);
        for (int n = 0; n < 2000 && sb_q.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain test%0d: %0d steps still pending, required 0", tid, sb_q.size());
            sb_q.delete();
        end else begin
            $display("test%0d: scoreboard drained, %0d checks so far", tid, checks);
        end
    endtask

    // Monitor: the outputs move on the edge that closes a ce cycle, so a
    // step is visible at the negedge following a negedge that saw ce=1.
    initial begin
        bit          prev_ce;
        bit          stepped;
        exp_t        e;
        logic [24:0] got;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            stepped = prev_ce;
            prev_ce = ce1;
            if (stepped && sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {hc1, vc1, hs1, vs1, de1, bl1, sof1, fl1};
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL step test%0d idx%0d: got %h (h=%0d v=%0d) expected %h (h=%0d v=%0d)",
                             e.tid, e.idx, got, got[24:16], got[15:6],
                             e.val, e.val[24:16], e.val[15:6]);
                end
            end
        end
    end

    initial begin
        logic [24:0] rst_val;
        rst_val = pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset values and divider, with the base small-frame test.
        set_inputs(T_BASE);
        repeat (3) @(negedge clk);
        check("reset dut1 outputs", 32'({hc1, vc1, hs1, vs1, de1, bl1, sof1, fl1}), 32'(rst_val));
        check("reset dut1 ce", 32'(ce1), 32'(0));
        check("reset dut4 outputs", 32'({hc4, vc4, hs4, vs4, de4, bl4, sof4, fl4}), 32'(rst_val));
        check("reset dut4 ce", 32'(ce4), 32'(0));
        #1 resb = 1'b1;
        push_run(T_BASE, 110);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("div4 ce after edge %0d", k), 32'(ce4), 32'((k % 4) == 3));
            check($sformatf("div1 ce after edge %0d", k), 32'(ce1), 32'(1));
        end
        drain(T_BASE);

        start_test(T_HWRAP, 60);
        drain(T_HWRAP);

        start_test(T_HEQ, 60);
        drain(T_HEQ);

        start_test(T_INTL, 150);
        drain(T_INTL);

        // h_total changes 9 -> 5 during line 2; takes effect after the wrap.
        start_test(T_SHADOW, 110);
        repeat (23) @(negedge clk);
        h_total = 9'd5;
        drain(T_SHADOW);

        // Asynchronous reset mid-line at (6,1) with de high.
        start_test(T_RESET, 16);
        drain(T_RESET);
        resb = 1'b0;
        #1;
        check("async reset outputs", 32'({hc1, vc1, hs1, vs1, de1, bl1, sof1, fl1}), 32'(rst_val));
        check("async reset ce", 32'(ce1), 32'(0));
        repeat (2) @(negedge clk);
        #1 resb = 1'b1;
        push_run(T_RESET, 20);
        drain(T_RESET);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vidtimgen.md
# vidtimgen

Parametrised, programmable successor to the fixed-mode ST video timing generator. It divides the master clock into a character-clock enable and runs horizontal and vertical counters against a timing set supplied on ports. The set is shadowed and applied only at frame boundaries. It produces sync, display-enable and blank strobes, and supports half-line-offset interlaced vsync. It sits between the clock generator and the shifter/video-address counter.

## Interface
- `HW`, default 9: horizontal counter width.
- `VW`, default 10: vertical counter width.
- `CLKDIV`, default 4: `clk` cycles per counter step (≥1).
- `clk` in 1: master clock.
- `resb` in 1: reset, asynchronous, active-low.
- `h_total` in HW: last column index (line has `h_total`+1 steps).
- `h_de_start`, `h_de_end` in HW: horizontal DE window.
- `h_sync_start`, `h_sync_end` in HW: hsync window.
- `v_total` in VW: last line index.
- `v_de_start`, `v_de_end` in VW: vertical DE window.
- `v_sync_start`, `v_sync_end` in VW: vsync line window.
- `interlace` in 1: enable field alternation.
- `ce` out 1: counter-step enable, one `clk` wide.
- `hsync_n`, `vsync_n` out 1: active-low syncs.
- `de` out 1: display enable.
- `blank_n` out 1: low while hsync or vsync is active.
- `field` out 1: current field, always 0 when not interlaced.
- `sof` out 1: start-of-frame pulse.
- `hcnt` out HW: horizontal counter.
- `vcnt` out VW: vertical counter.

## Operation
- Divider: a counter runs 0..CLKDIV-1. `ce`=1 in the cycle the divider equals CLKDIV-1. With CLKDIV=1, `ce` is constantly 1 after reset.
- Counter stepping on `ce`:
  - `hcnt`==sh_total: `hcnt`←0, else `hcnt`+1.
  - On the hcnt wrap: if `vcnt`==sv_total, `vcnt`←0, else `vcnt`+1.
- Shadow set (all timing inputs plus `interlace`):
  - Loaded on the frame wrap step, where hcnt=sh_total and vcnt=sv_total.
  - Also loaded on the first `ce` after reset release; a `first` flag is cleared by that step.
  - Input changes mid-frame have no effect until the next load.
- Window rule, applied to each of the h_de, h_sync, v_de and v_sync windows:
  - Active when start ≤ cnt < end.
  - start==end: never active.
  - start>end: wrap-around window, active when cnt ≥ start or cnt < end.
  - Counter values beyond total never occur, because wrap happens at total.
- `de` = hde window AND vde window.
- vsync, field 0: active from position (sv_sync_start, 0) up to but excluding (sv_sync_end, 0), in (line, column) order.
- vsync, field 1: same, with the column offset at sh_total>>1 instead of 0.
- Field:
  - On every frame wrap with shadow interlace=1, `field` toggles.
  - When shadow interlace=0, `field`←0 at the frame wrap.
  - The new field applies from line 0 of the new frame.
- `blank_n` = NOT(hsync active OR vsync active).
- `sof` = 1 for one `clk` on the step that enters (0,0).
- Simultaneous events:
  - A frame wrap that coincides with a shadow load uses the newly loaded values for decode of position (0,0).
  - If new `h_total`/`v_total` are smaller than the old counts, no counter is ever out of range, because loading occurs only at wrap.

## Timing
- Reset values:
  - divider=0, `ce`=0
  - `hcnt`=0, `vcnt`=0
  - `hsync_n`=1, `vsync_n`=1, `de`=0, `blank_n`=1
  - `field`=0, `sof`=0, shadow=0, first=1
- All outputs are registered.
- `hcnt`/`vcnt` update on the clock edge closing the `ce` cycle. On that same edge, `de`, syncs, `blank_n` and `sof` load the decode of the new counter values. Sync and DE therefore have zero lag relative to `hcnt`/`vcnt`.
- Outputs hold for CLKDIV clocks between steps. `sof` is high for exactly one `clk`.
- The first post-reset step loads the shadow and advances the counters from 0 to (1,0) using the loaded values. No `sof` occurs until the first frame wrap.
- Reset mid-frame returns every register to its reset value asynchronously. Operation restarts cleanly: the first `ce` arrives CLKDIV clocks after release.

## Test plan
- Divider: CLKDIV=4, reset release → `ce` high on clocks 4, 8, 12 after release. CLKDIV=1 → `ce` high every clock after release.
- Small frame, non-interlaced:
  - Settings: CLKDIV=1, h_total=9, h_de 2..8, h_sync 8..9, v_total=4, v_de 1..3, v_sync 4..0.
  - Required: `de` high on hcnt 2–7 of lines 1–2 only; `hsync_n` low at hcnt 8 only; `vsync_n` low for all of line 4.
  - Required: `sof` every 50 clocks; `field` stuck at 0.
- Wrap-around window: h_sync_start=8, h_sync_end=2, h_total=9 → `hsync_n` low at hcnt 8, 9, 0, 1 every line. start==end=5 → `hsync_n` never low.
- Interlace:
  - Settings: `interlace`=1, h_total=9, v_sync 4..0 (wrap).
  - Required: `field` alternates 0,1 on consecutive `sof`.
  - Required: in field 1, `vsync_n` falls at (4,4) and rises at (0,4); in field 0, it falls at (4,0) and rises at (0,0).
- Shadowing: change h_total 9→5 at mid-frame line 2 → line length stays 10 steps until `sof`, then becomes 6 steps. `hcnt` never exceeds 9.
- Async reset mid-line at hcnt=6, `de`=1 → all outputs reach reset values without a clock edge. After release, the counters restart from 0,0.
